// File: rtl/treasure_result_tx_pkg.sv
// Shared definitions for the FPGA-to-Arduino treasure report transmitter.
package treasure_result_tx_pkg;

  localparam int CODE_W_DEFAULT = 9;

  // Treasure codes produced by the image classifier
  localparam logic [8:0] CODE_NONE     = 9'd0;
  localparam logic [8:0] CODE_BLUE_SQ  = 9'd1;
  localparam logic [8:0] CODE_BLUE_TRI = 9'd2;
  localparam logic [8:0] CODE_BLUE_DIA = 9'd3;
  localparam logic [8:0] CODE_RED_SQ   = 9'd4;
  localparam logic [8:0] CODE_RED_TRI  = 9'd5;
  localparam logic [8:0] CODE_RED_DIA  = 9'd6;

  typedef enum logic [2:0] {
    IDLE,
    SEND_LO,
    SEND_HI,
    WAIT_ACK,
    WAIT_REL
  } tx_state;

endpackage

// File: rtl/treasure_result_tx_if.sv
// Classifier input, Arduino link pins and status outputs of the transmitter.
interface treasure_result_tx_if #(
  parameter int CODE_W = treasure_result_tx_pkg::CODE_W_DEFAULT
);

  logic [CODE_W-1:0] RESULT;
  logic              FRAME_DONE;
  logic              RX_ACK;
  logic              TX_DATA;
  logic              TX_CLK;
  logic              TX_VALID;
  logic              BUSY;
  logic [CODE_W-1:0] LAST_SENT;
  logic              TIMEOUT_ERR;

  // Transmitter side
  modport master (
    input  RESULT, FRAME_DONE, RX_ACK,
    output TX_DATA, TX_CLK, TX_VALID, BUSY, LAST_SENT, TIMEOUT_ERR
  );

  // Classifier / Arduino side
  modport slave (
    output RESULT, FRAME_DONE, RX_ACK,
    input  TX_DATA, TX_CLK, TX_VALID, BUSY, LAST_SENT, TIMEOUT_ERR
  );

endinterface

// File: rtl/treasure_result_tx_stability_filter.sv
// Per-frame code filter: reports a code once it has been seen on
// STABLE_FRAMES consecutive frames.
module result_stability_filter
  import treasure_result_tx_pkg::*;
#(
  parameter int CODE_W        = CODE_W_DEFAULT,
  parameter int STABLE_FRAMES = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [CODE_W-1:0] RESULT,
  input  logic              FRAME_DONE,
  output logic [CODE_W-1:0] candidate,
  output logic              stable
);

  localparam int               CNT_W   = $clog2(STABLE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_FRAMES);

  logic [CNT_W-1:0] count;

  // Track the current candidate and how many consecutive frames repeated it
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      candidate <= '0;
      count     <= '0;
    end else if (FRAME_DONE) begin
      if (RESULT == candidate) begin
        if (count != CNT_MAX) count <= count + 1'b1;
      end else begin
        candidate <= RESULT;
        count     <= CNT_W'(1);
      end
    end
  end

  assign stable = (count == CNT_MAX);

endmodule

// File: rtl/treasure_result_tx.sv
// Treasure report transmitter: filters classifier codes and bit-bangs each new
// stable code (plus even parity) to the Arduino, then waits for its ACK.
module treasure_result_tx
  import treasure_result_tx_pkg::*;
#(
  parameter int CODE_W        = CODE_W_DEFAULT,
  parameter int STABLE_FRAMES = 3,
  parameter int BIT_CYCLES    = 25,
  parameter int ACK_TIMEOUT   = 1000
) (
  input logic                  CLK,
  input logic                  RESET_N,
  treasure_result_tx_if.master bus
);

  localparam int FRAME_W = CODE_W + 1;
  localparam int CYC_W   = $clog2(BIT_CYCLES + 1);
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);

  tx_state              state, state_nx;
  logic [FRAME_W-1:0]   shift, shift_nx;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
  logic [CYC_W-1:0]     cyc_cnt, cyc_cnt_nx;
  logic [TO_W-1:0]      to_cnt, to_cnt_nx;
  logic [CODE_W-1:0]    sent_code, sent_code_nx;
  logic [CODE_W-1:0]    last_sent, last_sent_nx;
  logic                 timeout_err, timeout_err_nx;
  logic                 ack_s1, ack_s2;
  logic [CODE_W-1:0]    candidate;
  logic                 stable;
  logic                 half_done;

  result_stability_filter #(
    .CODE_W        (CODE_W),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_filter (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .RESULT     (bus.RESULT),
    .FRAME_DONE (bus.FRAME_DONE),
    .candidate  (candidate),
    .stable     (stable)
  );

  // Two-flop synchronizer for the asynchronous Arduino acknowledge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= bus.RX_ACK;
      ack_s2 <= ack_s1;
    end
  end

  // Transfer state registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      shift       <= '0;
      bit_cnt     <= '0;
      cyc_cnt     <= '0;
      to_cnt      <= '0;
      sent_code   <= '0;
      last_sent   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      shift       <= shift_nx;
      bit_cnt     <= bit_cnt_nx;
      cyc_cnt     <= cyc_cnt_nx;
      to_cnt      <= to_cnt_nx;
      sent_code   <= sent_code_nx;
      last_sent   <= last_sent_nx;
      timeout_err <= timeout_err_nx;
    end
  end

  assign half_done = (cyc_cnt == CYC_W'(BIT_CYCLES - 1));

  // Next-state logic: launch, bit timing, ACK handshake and timeout
  always_comb begin
    state_nx       = state;
    shift_nx       = shift;
    bit_cnt_nx     = bit_cnt;
    cyc_cnt_nx     = cyc_cnt;
    to_cnt_nx      = to_cnt;
    sent_code_nx   = sent_code;
    last_sent_nx   = last_sent;
    timeout_err_nx = timeout_err;

    unique case (state)
      IDLE: begin
        // Uses the registered candidate, so a same-cycle FRAME_DONE cannot
        // alter the code being launched.
        if (stable && (candidate != last_sent)) begin
          shift_nx     = {candidate, ^candidate};
          sent_code_nx = candidate;
          bit_cnt_nx   = BIT_W'(FRAME_W);
          cyc_cnt_nx   = '0;
          state_nx     = SEND_LO;
        end
      end
      SEND_LO: begin
        if (half_done) begin
          cyc_cnt_nx = '0;
          state_nx   = SEND_HI;
        end else begin
          cyc_cnt_nx = cyc_cnt + 1'b1;
        end
      end
      SEND_HI: begin
        if (half_done) begin
          cyc_cnt_nx = '0;
          shift_nx   = shift << 1;
          bit_cnt_nx = bit_cnt - 1'b1;
          if (bit_cnt == BIT_W'(1)) begin
            to_cnt_nx = '0;
            state_nx  = WAIT_ACK;
          end else begin
            state_nx  = SEND_LO;
          end
        end else begin
          cyc_cnt_nx = cyc_cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        // ACK is tested first so it wins over a coincident timeout
        if (ack_s2) begin
          last_sent_nx   = sent_code;
          timeout_err_nx = 1'b0;
          state_nx       = WAIT_REL;
        end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          timeout_err_nx = 1'b1;
          state_nx       = IDLE;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
      end
      WAIT_REL: begin
        if (!ack_s2) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.TX_DATA     = ((state == SEND_LO) || (state == SEND_HI)) ? shift[FRAME_W-1] : 1'b0;
  assign bus.TX_CLK      = (state == SEND_HI);
  assign bus.TX_VALID    = (state == WAIT_ACK);
  assign bus.BUSY        = (state != IDLE);
  assign bus.LAST_SENT   = last_sent;
  assign bus.TIMEOUT_ERR = timeout_err;

endmodule

// File: tb/tb_treasure_result_tx.sv
// Self-checking bench for treasure_result_tx against a streak/transaction model.
module tb_treasure_result_tx;
  import treasure_result_tx_pkg::*;

  localparam int CW     = 9;
  localparam int STABLE = 3;
  localparam int BITC   = 2;
  localparam int ACKTO  = 20;
  localparam int XFER   = (CW + 1) * 2 * BITC;

  logic CLK = 1'b0;
  logic RESET_N;

  treasure_result_tx_if #(.CODE_W(CW)) bus ();

  treasure_result_tx #(
    .CODE_W        (CW),
    .STABLE_FRAMES (STABLE),
    .BIT_CYCLES    (BITC),
    .ACK_TIMEOUT   (ACKTO)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Model: streak of identical frame codes plus link-level results
  logic [CW-1:0] m_code;
  int            m_len;
  logic [CW-1:0] exp_last;
  logic          exp_terr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW:0] exp_frame(input logic [CW-1:0] c);
    int ones;
    ones = $countones(c);
    return {c, ones[0]};
  endfunction

  function automatic bit m_launch();
    return (m_len >= STABLE) && (m_code != exp_last);
  endfunction

  task automatic model_reset();
    m_code   = '0;
    m_len    = 0;
    exp_last = '0;
    exp_terr = 1'b0;
  endtask

  task automatic send_frame(input logic [CW-1:0] code);
    @(posedge CLK); #1;
    bus.RESULT     = code;
    bus.FRAME_DONE = 1'b1;
    @(posedge CLK); #1;
    bus.FRAME_DONE = 1'b0;
    if (code == m_code) m_len++;
    else begin
      m_code = code;
      m_len  = 1;
    end
  endtask

  // n frames of code, then check that a launch happens exactly one cycle later (or not at all)
  task automatic stable_launch(input logic [CW-1:0] code, input int n, output bit launched);
    for (int i = 0; i < n; i++) send_frame(code);
    @(negedge CLK);
    chk("pre_launch_busy", 32'(bus.BUSY), 32'd0);
    @(negedge CLK);
    launched = m_launch();
    chk("launch_busy", 32'(bus.BUSY), 32'(launched));
  endtask

  // Collect bits on TX_CLK rising edges until TX_VALID; pre = send cycles already observed
  task automatic capture_frame(input logic [CW-1:0] code, input int pre);
    logic [CW:0] bits;
    int          nb, cyc, unstable;
    logic        prev_clk, held;
    bit          done;
    bits = '0; nb = 0; cyc = pre; unstable = 0; prev_clk = 1'b0; held = 1'b0; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLK);
      if (bus.TX_VALID) done = 1;
      else if (bus.BUSY) begin
        cyc++;
        if (bus.TX_CLK && !prev_clk) begin
          bits = {bits[CW-1:0], bus.TX_DATA};
          nb++;
          held = bus.TX_DATA;
        end else if (bus.TX_CLK && (bus.TX_DATA !== held)) begin
          unstable++;
        end
        prev_clk = bus.TX_CLK;
      end
    end
    chk("frame_reached_valid", 32'(done), 32'd1);
    chk("frame_bits", 32'(bits), 32'(exp_frame(code)));
    chk("frame_nbits", 32'(nb), 32'(CW + 1));
    chk("frame_cycles", 32'(cyc), 32'(XFER));
    chk("data_stable_hi", 32'(unstable), 32'd0);
    chk("wait_ack_txclk", 32'(bus.TX_CLK), 32'd0);
    chk("wait_ack_txdata", 32'(bus.TX_DATA), 32'd0);
  endtask

  // Called at the negedge where TX_VALID was first seen
  task automatic do_ack(input int delay, input logic [CW-1:0] code, output bit relaunched);
    bit ok;
    repeat (delay) @(negedge CLK);
    #1 bus.RX_ACK = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      if (!bus.TX_VALID) ok = 1;
    end
    chk("ack_seen", 32'(ok), 32'd1);
    exp_last = code;
    exp_terr = 1'b0;
    chk("ack_last_sent", 32'(bus.LAST_SENT), 32'(exp_last));
    chk("ack_timeout_err", 32'(bus.TIMEOUT_ERR), 32'(exp_terr));
    chk("wait_rel_busy", 32'(bus.BUSY), 32'd1);
    #1 bus.RX_ACK = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge CLK);
      if (!bus.BUSY) ok = 1;
    end
    chk("release_idle", 32'(ok), 32'd1);
    @(negedge CLK);
    relaunched = m_launch();
    chk("after_rel_busy", 32'(bus.BUSY), 32'(relaunched));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] a, b, c, d, e, code;
    logic [CW-1:0] seq [5];
    bit            go, rl;
    int            n, busy_cnt;

    RESET_N = 1'b0;
    bus.RESULT = '0; bus.FRAME_DONE = 1'b0; bus.RX_ACK = 1'b0;
    model_reset();
    #1;
    chk("rst_tx_data", 32'(bus.TX_DATA), 32'd0);
    chk("rst_tx_clk", 32'(bus.TX_CLK), 32'd0);
    chk("rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_last_sent", 32'(bus.LAST_SENT), 32'd0);
    chk("rst_timeout_err", 32'(bus.TIMEOUT_ERR), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // Basic report of RED_SQ, ACK three cycles after TX_VALID
    stable_launch(CODE_RED_SQ, 3, go);
    if (go) begin
      capture_frame(CODE_RED_SQ, 1);
      do_ack(3, CODE_RED_SQ, rl);
    end

    // Broken streak must not launch
    do a = CW'($urandom_range(0, 511)); while (a == exp_last);
    do b = CW'($urandom_range(0, 511)); while (b == a);
    seq[0] = a; seq[1] = a; seq[2] = b; seq[3] = a; seq[4] = a;
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i]);
      @(negedge CLK);
      chk("broken_streak_busy_a", 32'(bus.BUSY), 32'd0);
      @(negedge CLK);
      chk("broken_streak_busy_b", 32'(bus.BUSY), 32'd0);
    end
    stable_launch(a, 1, go);
    if (go) begin
      capture_frame(a, 1);
      do_ack(int'($urandom_range(0, 5)), a, rl);
    end

    // Stable code equal to LAST_SENT is not re-reported
    stable_launch(exp_last, 3, go);
    busy_cnt = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.BUSY) busy_cnt++;
    end
    chk("same_code_busy", 32'(busy_cnt), 32'd0);

    // ACK timeout then immediate retransmit
    do c = CW'($urandom_range(0, 511)); while (c == exp_last);
    stable_launch(c, 3, go);
    if (go) begin
      capture_frame(c, 1);
      n = 1;
      for (int i = 0; i < 100 && bus.TX_VALID; i++) begin
        @(negedge CLK);
        if (bus.TX_VALID) n++;
      end
      exp_terr = 1'b1;
      chk("timeout_cycles", 32'(n), 32'(ACKTO));
      chk("timeout_busy", 32'(bus.BUSY), 32'd0);
      chk("timeout_err_set", 32'(bus.TIMEOUT_ERR), 32'(exp_terr));
      chk("timeout_last_kept", 32'(bus.LAST_SENT), 32'(exp_last));
      @(negedge CLK);
      chk("retry_busy", 32'(bus.BUSY), 32'(m_launch()));
      capture_frame(c, 1);
      do_ack(2, c, rl);
    end

    // New stable code arriving mid-transfer is sent right after WAIT_REL
    d = (exp_last == CODE_RED_SQ) ? CODE_BLUE_SQ : CODE_RED_SQ;
    e = CODE_RED_DIA;
    stable_launch(d, 3, go);
    if (go) begin
      fork
        capture_frame(d, 1);
        begin
          repeat (5) @(posedge CLK);
          for (int i = 0; i < 3; i++) send_frame(e);
        end
      join
      do_ack(1, d, rl);
      if (rl) begin
        capture_frame(e, 1);
        do_ack(0, e, rl);
      end
    end

    // Reset during SEND_HI
    stable_launch(CODE_RED_TRI, 3, go);
    go = 0;
    for (int i = 0; i < 20 && !go; i++) begin
      @(negedge CLK);
      if (bus.TX_CLK) go = 1;
    end
    chk("reached_send_hi", 32'(go), 32'd1);
    RESET_N = 1'b0;
    model_reset();
    #1;
    chk("midrst_tx_clk", 32'(bus.TX_CLK), 32'd0);
    chk("midrst_tx_data", 32'(bus.TX_DATA), 32'd0);
    chk("midrst_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("midrst_busy", 32'(bus.BUSY), 32'd0);
    chk("midrst_last_sent", 32'(bus.LAST_SENT), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    stable_launch(CODE_BLUE_DIA, 3, go);
    if (go) begin
      capture_frame(CODE_BLUE_DIA, 1);
      do_ack(3, CODE_BLUE_DIA, rl);
    end

    // ACK glitch while idle is ignored
    @(negedge CLK); #1 bus.RX_ACK = 1'b1;
    @(negedge CLK); #1 bus.RX_ACK = 1'b0;
    repeat (4) @(negedge CLK);
    chk("glitch_busy", 32'(bus.BUSY), 32'd0);
    chk("glitch_last_sent", 32'(bus.LAST_SENT), 32'(exp_last));

    // Randomized reports, including code 0 and a repeat of LAST_SENT
    for (int it = 0; it < 6; it++) begin
      if (it == 0) code = CODE_NONE;
      else if (it == 3) code = exp_last;
      else code = CW'($urandom_range(0, 511));
      stable_launch(code, 3, go);
      if (go) begin
        capture_frame(code, 1);
        do_ack(int'($urandom_range(0, 5)), code, rl);
      end else begin
        repeat (4) @(negedge CLK);
        chk("rand_no_launch_busy", 32'(bus.BUSY), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
